// File: rtl/cp0_if.sv
// MTC0 / MFC0 access bus between the MEM stage and the CP0 register file.
interface cp0_if;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;

  modport master (output wen, output waddr, output wdata, output raddr, input rdata);
  modport slave  (input wen, input waddr, input wdata, input raddr, output rdata);
endinterface

// File: rtl/cp0_reg.sv
// CP0 register file: Status, Cause, EPC, BadVAddr, EBase, plus Count/Compare timer.
// Optional feature macro: CP0_TIMER_EN (Count, Compare and timer interrupt present when defined).
module cp0_reg #(
  parameter logic [31:0] EBASE_RESET  = 32'hBFC0_0000,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  cp0_if.slave        bus,
  input  logic [5:0]  int_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] ebase_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] status_r, epc_r, ebase_r, badvaddr_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [1:0]  cause_iv_r, cause_swi_r;
  logic [4:0]  exc_code_r;

  logic        exc_entry_s, eret_s, ade_s, mtc0_s, ti_s;
  logic [4:0]  exc_code_s;
  logic [31:0] count_s, compare_s;

  // Decode the resolved exception code; unknown nonzero codes take no action.
  always_comb begin
    exc_entry_s = 1'b0;
    eret_s      = 1'b0;
    ade_s       = 1'b0;
    exc_code_s  = 5'd0;
    case (exception_type_i)
      32'h0000_0001: begin exc_entry_s = 1'b1; exc_code_s = 5'd0;  end
      32'h0000_0004: begin exc_entry_s = 1'b1; exc_code_s = 5'd4;  ade_s = 1'b1; end
      32'h0000_0005: begin exc_entry_s = 1'b1; exc_code_s = 5'd5;  ade_s = 1'b1; end
      32'h0000_0008: begin exc_entry_s = 1'b1; exc_code_s = 5'd8;  end
      32'h0000_0009: begin exc_entry_s = 1'b1; exc_code_s = 5'd9;  end
      32'h0000_000A: begin exc_entry_s = 1'b1; exc_code_s = 5'd10; end
      32'h0000_000C: begin exc_entry_s = 1'b1; exc_code_s = 5'd12; end
      32'h0000_000E: begin eret_s = 1'b1; end
      default: begin exc_entry_s = 1'b0; end
    endcase
    mtc0_s = bus.wen && (exception_type_i == 32'h0000_0000);
  end

  // Exception entry / ERET / MTC0 updates of the architectural registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r    <= STATUS_RESET;
      ebase_r     <= EBASE_RESET;
      epc_r       <= 32'h0000_0000;
      badvaddr_r  <= 32'h0000_0000;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_iv_r  <= 2'd0;
      cause_swi_r <= 2'd0;
      exc_code_r  <= 5'd0;
    end else begin
      cause_ip_r <= int_i;
      if (exc_entry_s) begin
        if (!status_r[1]) begin
          epc_r      <= is_in_delayslot_i ? (pc_i - 32'd4) : pc_i;
          cause_bd_r <= is_in_delayslot_i;
        end
        status_r[1] <= 1'b1;
        exc_code_r  <= exc_code_s;
        if (ade_s) begin
          badvaddr_r <= bad_addr_i;
        end
      end else if (eret_s) begin
        status_r[1] <= 1'b0;
      end else if (mtc0_s) begin
        case (bus.waddr)
          5'd12: status_r <= (status_r & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
          5'd13: begin
            cause_iv_r  <= bus.wdata[23:22];
            cause_swi_r <= bus.wdata[9:8];
          end
          5'd14: epc_r   <= bus.wdata;
          5'd15: ebase_r <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_r, compare_r;
  logic        tick_r, timer_int_r;

  // Count advances on every second clock; Compare write acknowledges the timer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r     <= 32'h0000_0000;
      compare_r   <= 32'h0000_0000;
      tick_r      <= 1'b0;
      timer_int_r <= 1'b0;
    end else begin
      if (mtc0_s && (bus.waddr == 5'd9)) begin
        count_r <= bus.wdata;
        tick_r  <= 1'b0;
      end else begin
        count_r <= count_r + {31'd0, tick_r};
        tick_r  <= ~tick_r;
      end
      if (mtc0_s && (bus.waddr == 5'd11)) begin
        compare_r   <= bus.wdata;
        timer_int_r <= 1'b0;
      end else if ((compare_r != 32'h0000_0000) && (count_r == compare_r)) begin
        timer_int_r <= 1'b1;
      end
    end
  end

  assign count_s   = count_r;
  assign compare_s = compare_r;
  assign ti_s      = timer_int_r;
`else
  assign count_s   = 32'h0000_0000;
  assign compare_s = 32'h0000_0000;
  assign ti_s      = 1'b0;
`endif

  assign status_o    = status_r;
  assign epc_o       = epc_r;
  assign ebase_o     = ebase_r;
  assign badvaddr_o  = badvaddr_r;
  assign count_o     = count_s;
  assign compare_o   = compare_s;
  assign timer_int_o = ti_s;
  assign cause_o     = {cause_bd_r, ti_s, 6'd0, cause_iv_r, 6'd0,
                        cause_ip_r[5] | ti_s, cause_ip_r[4:0],
                        cause_swi_r, 1'b0, exc_code_r, 2'b00};

  // MFC0 read mux; unmapped numbers read zero.
  always_comb begin
    case (bus.raddr)
      5'd8:    bus.rdata = badvaddr_r;
      5'd9:    bus.rdata = count_s;
      5'd11:   bus.rdata = compare_s;
      5'd12:   bus.rdata = status_r;
      5'd13:   bus.rdata = cause_o;
      5'd14:   bus.rdata = epc_r;
      5'd15:   bus.rdata = ebase_r;
      default: bus.rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios then random traffic against a register-number model.
module tb_cp0_reg;
  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  int_i;
  logic [31:0] exception_type_i, pc_i, bad_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] status_o, cause_o, epc_o, ebase_o, badvaddr_o, count_o, compare_o;
  logic        timer_int_o;

  cp0_if bus ();

  cp0_reg dut (
    .clk(clk), .resetn(resetn), .bus(bus), .int_i(int_i),
    .exception_type_i(exception_type_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .ebase_o(ebase_o),
    .badvaddr_o(badvaddr_o), .count_o(count_o), .compare_o(compare_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: software-visible state indexed by CP0 register number.
  logic [31:0] m_reg [0:31];
  logic [5:0]  m_ip;
  logic        m_timer;
  logic        m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return (m_reg[13] & 32'h80C0_037C) |
           {1'b0, m_timer, 14'd0, m_ip[5] | m_timer, m_ip[4:0], 10'd0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8, 5'd9, 5'd11, 5'd12, 5'd14, 5'd15: return m_reg[a];
      5'd13: return m_cause();
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0000_0000;
    m_reg[12] = 32'h0040_0000;
    m_reg[15] = 32'hBFC0_0000;
    m_ip = 6'd0; m_timer = 1'b0; m_phase = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] nr [0:31];
    logic entry, eret, mtc, hit;
    nr = m_reg;
    entry = exception_type_i inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC};
    eret  = (exception_type_i == 32'hE);
    mtc   = bus.wen && (exception_type_i == 32'h0);
    hit   = (m_reg[11] != 32'h0) && (m_reg[9] == m_reg[11]);
    if (entry) begin
      if (m_reg[12][1] == 1'b0) begin
        nr[14] = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
        nr[13][31] = is_in_delayslot_i;
      end
      nr[12][1] = 1'b1;
      nr[13][6:2] = (exception_type_i == 32'h1) ? 5'd0 : exception_type_i[4:0];
      if (exception_type_i == 32'h4 || exception_type_i == 32'h5) nr[8] = bad_addr_i;
    end else if (eret) begin
      nr[12][1] = 1'b0;
    end else if (mtc) begin
      if (bus.waddr == 5'd12) nr[12] = (m_reg[12] & ~32'h0000_FF03) | (bus.wdata & 32'h0000_FF03);
      if (bus.waddr == 5'd13) nr[13] = (m_reg[13] & ~32'h00C0_0300) | (bus.wdata & 32'h00C0_0300);
      if (bus.waddr == 5'd14 || bus.waddr == 5'd15) nr[bus.waddr] = bus.wdata;
`ifdef CP0_TIMER_EN
      if (bus.waddr == 5'd11) nr[11] = bus.wdata;
`endif
    end
`ifdef CP0_TIMER_EN
    if (mtc && bus.waddr == 5'd9) begin
      nr[9] = bus.wdata; m_phase = 1'b0;
    end else begin
      nr[9] = m_reg[9] + (m_phase ? 32'd1 : 32'd0); m_phase = ~m_phase;
    end
    if (mtc && bus.waddr == 5'd11) m_timer = 1'b0;
    else if (hit) m_timer = 1'b1;
`endif
    m_reg = nr;
    m_ip  = int_i;
  endtask

  task automatic check_all();
    check("status", status_o, m_reg[12]);
    check("cause", cause_o, m_cause());
    check("epc", epc_o, m_reg[14]);
    check("ebase", ebase_o, m_reg[15]);
    check("badvaddr", badvaddr_o, m_reg[8]);
    check("count", count_o, m_reg[9]);
    check("compare", compare_o, m_reg[11]);
    check("timer_int", {31'd0, timer_int_o}, {31'd0, m_timer});
    check("rdata", bus.rdata, m_read(bus.raddr));
  endtask

  task automatic idle();
    bus.wen = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
    exception_type_i = 32'h0; pc_i = 32'h0; is_in_delayslot_i = 1'b0; bad_addr_i = 32'h0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.wen = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
  endtask

  task automatic exc(input logic [31:0] code, input logic [31:0] pc, input logic ds, input logic [31:0] bad);
    exception_type_i = code; pc_i = pc; is_in_delayslot_i = ds; bad_addr_i = bad;
    tick();
  endtask

  initial begin
    logic [31:0] codes [0:8];
    logic [4:0]  addrs [0:7];
    logic [31:0] saved;
    int waited;
    codes = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE, 32'hE};
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    resetn = 1'b0; int_i = 6'd0; bus.raddr = 5'd12; idle();
    model_reset();
    #22;
    check("rst_status", status_o, 32'h0040_0000);
    resetn = 1'b1;
    #1;
    check("rst_ebase", ebase_o, 32'hBFC0_0000);
    check("rst_cause", cause_o, 32'h0000_0000);
    check("rst_timer", {31'd0, timer_int_o}, 32'h0);
    @(negedge clk);

    // SYSCALL then ERET
    exc(32'h8, 32'hBFC0_0100, 1'b0, 32'h0);
    check("sys_epc", epc_o, 32'hBFC0_0100);
    check("sys_exccode", {27'd0, cause_o[6:2]}, 32'd8);
    check("sys_exl", {31'd0, status_o[1]}, 32'd1);
    exc(32'hE, 32'h0, 1'b0, 32'h0);
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // Overflow in a delay slot, then a nested exception with EXL set
    exc(32'hC, 32'h8000_0010, 1'b1, 32'h0);
    check("ov_epc", epc_o, 32'h8000_000C);
    check("ov_bd", {31'd0, cause_o[31]}, 32'd1);
    exc(32'h9, 32'h1234_5678, 1'b0, 32'h0);
    check("nested_epc", epc_o, 32'h8000_000C);
    exc(32'hE, 32'h0, 1'b0, 32'h0);

    // Address error load, BadVAddr is read-only
    exc(32'h4, 32'h8000_0020, 1'b0, 32'h8000_0003);
    check("adel_bad", badvaddr_o, 32'h8000_0003);
    check("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
    exc(32'hE, 32'h0, 1'b0, 32'h0);
    mtc0(5'd8, 32'h0);
    check("bad_ro", badvaddr_o, 32'h8000_0003);

    // Unknown code acts as no exception
    saved = status_o;
    exc(32'h3, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check("unknown_code", status_o, saved);

    // Exception beats a simultaneous Status write
    bus.wen = 1'b1; bus.waddr = 5'd12; bus.wdata = 32'hFFFF_FFFF;
    exc(32'h9, 32'h8000_0100, 1'b0, 32'h0);
    check("exc_beats_wen", status_o, 32'h0040_0002);
    exc(32'hE, 32'h0, 1'b0, 32'h0);
    mtc0(5'd12, 32'hFFFF_FFFF);
    check("status_mask", status_o, 32'h0040_FF03);
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_mask", cause_o & 32'h00C0_0300, 32'h00C0_0300);

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd5);
    waited = 0;
    while (timer_int_o !== 1'b1 && waited < 30) begin tick(); waited++; end
    check("timer_latency", waited, 32'd10);
    check("timer_ti", {31'd0, cause_o[30]}, 32'd1);
    check("timer_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'd100);
    check("timer_clear", {31'd0, timer_int_o}, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    tick(); tick();
    check("count_wrap", count_o, 32'h0000_0000);
`else
    mtc0(5'd9, 32'h1234);
    mtc0(5'd11, 32'd5);
    for (int i = 0; i < 12; i++) tick();
    check("no_count", count_o, 32'h0);
    check("no_timer", {31'd0, timer_int_o}, 32'h0);
`endif

    // Random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      int_i = 6'($urandom);
      bus.raddr = addrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0)
        exception_type_i = codes[$urandom_range(0, 8)];
      pc_i = $urandom & 32'hFFFF_FFFC; is_in_delayslot_i = 1'($urandom); bad_addr_i = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        bus.wen = 1'b1; bus.waddr = addrs[$urandom_range(0, 7)];
        bus.wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      end
      tick();
      if (i == 300) begin
        #2 resetn = 1'b0;
        model_reset();
        #1 check_all();
        #2 resetn = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
